// File: rtl/apple_gen.sv
// Apple placement, drawing and eat detection for the snake game.
// A grid-aligned candidate comes from an LFSR and is vetted against the snake for one full frame before it is shown.
module apple_gen #(
    parameter int          APPLE_SIZE = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       VGA_clk,
    input  logic       SWRES,
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_column,
    input  logic       head_on,
    input  logic       body_on,
    output logic       apple_on,
    output logic       got_apple,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        PLACE,
        WAIT_SOF,
        SCAN,
        ACTIVE,
        EAT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [10:0] apple_x, apple_y;
    logic [10:0] cand_x, cand_y;
    logic        hit, conflict;

    logic [6:0]  ix;
    logic [5:0]  iy;
    logic        cand_valid;
    logic [10:0] cand_nx, cand_ny;
    logic [10:0] pc, pr, sz;
    logic        apple_pix, cand_on;
    logic        sof, eof;
    logic        conflict_now, hit_now;
    logic        eat_go;

    // x^16 + x^14 + x^13 + x^11 + 1
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign ix         = lfsr[6:0];
    assign iy         = lfsr[14:9];
    assign cand_valid = (ix < 7'd77) && (iy < 6'd57);
    assign cand_nx    = 11'd20 + 11'd10 * {4'd0, ix};
    assign cand_ny    = 11'd20 + 11'd10 * {5'd0, iy};

    // Widen before adding the extent so pixel + size cannot wrap.
    assign pc = {1'b0, pixel_column};
    assign pr = {1'b0, pixel_row};
    assign sz = 11'(APPLE_SIZE);

    assign apple_pix = (apple_x <= pc + sz) && (apple_x >= pc) &&
                       (apple_y <= pr + sz) && (apple_y >= pr);
    assign cand_on   = (cand_x <= pc + sz) && (cand_x >= pc) &&
                       (cand_y <= pr + sz) && (cand_y >= pr);
    assign apple_on  = (state == ACTIVE) && apple_pix;

    assign sof = (pixel_row == 10'd0)   && (pixel_column == 10'd0);
    assign eof = (pixel_row == 10'd599) && (pixel_column == 10'd799);

    assign conflict_now = cand_on && (head_on || body_on);
    assign hit_now      = apple_on && head_on;
    assign eat_go       = (state == ACTIVE) && eof && (hit || hit_now);

    always_ff @(posedge VGA_clk) begin
        if (!SWRES) state <= PLACE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PLACE:    if (cand_valid) state_nxt = WAIT_SOF;
            WAIT_SOF: if (sof) state_nxt = SCAN;
            SCAN:     if (eof) state_nxt = (conflict || conflict_now) ? PLACE : ACTIVE;
            ACTIVE:   if (eat_go) state_nxt = EAT;
            EAT:      state_nxt = PLACE;
            default:  state_nxt = PLACE;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (!SWRES) begin
            lfsr      <= LFSR_SEED;
            score     <= 8'd0;
            got_apple <= 1'b0;
            hit       <= 1'b0;
            conflict  <= 1'b0;
            apple_x   <= 11'd0;
            apple_y   <= 11'd0;
            cand_x    <= 11'd0;
            cand_y    <= 11'd0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsr_fb};
            got_apple <= eat_go;
            case (state)
                PLACE: begin
                    if (cand_valid) begin
                        cand_x <= cand_nx;
                        cand_y <= cand_ny;
                    end
                end
                WAIT_SOF: begin
                    if (sof) conflict <= conflict_now;
                end
                SCAN: begin
                    conflict <= conflict || conflict_now;
                    if (eof) begin
                        hit <= 1'b0;
                        if (!(conflict || conflict_now)) begin
                            apple_x <= cand_x;
                            apple_y <= cand_y;
                        end
                    end
                end
                ACTIVE: begin
                    if (eof) begin
                        hit <= 1'b0;
                        // Score updates alongside the pulse so it reads new in the EAT cycle.
                        if (hit || hit_now) score <= (score == 8'hFF) ? score : score + 8'd1;
                    end else begin
                        hit <= hit || hit_now;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/apple_gen.md
# apple_gen

Apple placement and consumption unit for the snake game. It sits directly upstream of the snake head/body unit on the VGA pixel clock and supplies that unit's `got_apple` pulse. It does three jobs:
- Places an apple on the 10-pixel movement grid using an LFSR.
- Rejects placements that overlap the snake, using that unit's `head_on`/`body_on` pixel flags.
- Draws the apple (`apple_on`), detects when the head eats it, and keeps a score.

## Interface
Parameters:
- `APPLE_SIZE`, 8: apple extent term. Geometry is identical to the head sprite, giving 9x9 pixels.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `VGA_clk`  in  1  pixel clock. This is the only clock.
- `SWRES`  in  1  reset. Synchronous, active-low.
- `pixel_row`  in  10  current scan row, 0..599 visible.
- `pixel_column`  in  10  current scan column, 0..799 visible.
- `head_on`  in  1  snake head covers the current pixel.
- `body_on`  in  1  snake body covers the current pixel.
- `apple_on`  out  1  apple covers the current pixel. Combinational.
- `got_apple`  out  1  one-cycle registered pulse: apple eaten.
- `score`  out  8  apples eaten. Saturates at 255.

## Operation
Grid and geometry:
- Apple position: `apple_x = 20 + 10*ix` with `ix` in 0..76, giving 20..780. `apple_y = 20 + 10*iy` with `iy` in 0..56, giving 20..580.
- `apple_on` is 1 when all of the following hold and state is ACTIVE; otherwise 0:
  - `apple_x <= pixel_column + APPLE_SIZE`
  - `apple_x >= pixel_column`
  - `apple_y <= pixel_row + APPLE_SIZE`
  - `apple_y >= pixel_row`
- Candidate overlap `cand_on` uses the same comparison on the candidate registers, with no state gating.
- All comparisons are 11-bit unsigned, so `pixel + 8` cannot wrap.

LFSR:
- 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
- Shifts every `VGA_clk` cycle in every state, including while reset is released.
- Candidate fields: `ix = lfsr[6:0]` and `iy = lfsr[14:9]`. A candidate is valid only when both `ix < 77` and `iy < 57` in the same cycle.

Frame markers:
- SOF: `pixel_row==0 && pixel_column==0`.
- EOF: `pixel_row==599 && pixel_column==799`.

States:
- PLACE: on the first cycle with a valid candidate, latch `cand_x`/`cand_y` and go to WAIT_SOF. Otherwise stay.
- WAIT_SOF: on SOF, clear `conflict` and go to SCAN. Set `conflict` if the SOF pixel itself has `cand_on && (head_on || body_on)`.
- SCAN: set `conflict` on any cycle where `cand_on && (head_on || body_on)`. At EOF:
  - If `conflict` (including the EOF pixel): go to PLACE.
  - Otherwise: copy the candidate to `apple_x`/`apple_y`, clear `hit`, and go to ACTIVE.
- ACTIVE: set `hit` on any cycle where `apple_on && head_on`. At EOF:
  - If `hit` (including the EOF pixel): go to EAT.
  - Otherwise: clear `hit` and stay.
- EAT: one cycle only.
  - `got_apple` = 1.
  - `score` = min(`score`+1, 255).
  - `apple_on` = 0.
  - Go to PLACE.
- `body_on` alone never causes an eat.

Reset, taken when `SWRES`==0 at a clock edge, from any state:
- state = PLACE
- `lfsr` = `LFSR_SEED`
- `score` = 0
- `got_apple` = 0
- `hit` = 0, `conflict` = 0
- `apple_x` = `apple_y` = 0, `cand_x` = `cand_y` = 0
- `apple_on` is 0 during reset because state is not ACTIVE.

Boundary conditions:
- Reset on the same edge as an EOF with `hit`: reset wins. No pulse, `score` = 0.
- `score` at 255 on an eat: `got_apple` still pulses and `score` holds at 255.
- Snake permanently covering the candidate: the unit loops PLACE/WAIT_SOF/SCAN. `apple_on` and `got_apple` stay 0.

## Timing
- `apple_on` is valid in the same cycle as its `pixel_row`/`pixel_column`, aligned with `head_on`/`body_on`.
- `got_apple` is high for exactly one `VGA_clk` cycle, in the cycle after the EOF edge. It is never high on consecutive cycles. This is required because the downstream unit adds one segment per high cycle.
- Eat to new apple visible: at least 1 frame. Minimum path is EAT, then PLACE (at least 1 cycle), then WAIT_SOF, then a full SCAN frame. The new apple first appears on the frame after the scan.
- Reset release to first visible apple: the apple is visible on the second SOF after release in the no-conflict case, provided a valid candidate appears before the first SOF.

## Test plan
1. Reset and placement: hold `SWRES`=0 for 3 cycles, then scan frames with `head_on`=`body_on`=0.
   - During reset: `score`=0, `got_apple`=0, `apple_on`=0.
   - By the third frame: `apple_on` is high for exactly 81 pixels per frame, as a 9x9 block whose bottom-right corner is (`apple_x`, `apple_y`). `apple_x` is a multiple of 10 in 20..780; `apple_y` is a multiple of 10 in 20..580.
2. Eat: drive `head_on`=1 on one pixel where `apple_on`=1.
   - `got_apple`=1 for exactly 1 cycle, one cycle after pixel (599,799).
   - `score` goes from 0 to 1.
   - `apple_on`=0 for the whole next frame.
3. No false eat:
   - `head_on`=1 everywhere except the apple's pixels for 5 frames: no pulse, `score` unchanged.
   - `body_on`=1 over the apple: no pulse, `score` unchanged.
4. Placement conflict: hold `body_on`=1 for every pixel, starting from reset.
   - For 10 frames: `apple_on`=0 and no pulse.
   - After releasing: the apple appears within 3 frames.
5. Saturation: perform 257 eats. `score` reads 255 and `got_apple` pulses 257 times.
6. Reset collision: assert `SWRES`=0 on the EOF edge of a frame where `hit` is set. `got_apple` never rises and `score`=0.
